// File: rtl/memory_array.sv
// memory_array: single-port-write / single-port-read word memory with
// step-gated, byte-masked writes, a write-first read bypass and a
// zero-sweep engine that runs after reset release or on request.
module memory_array #(
  parameter int           DATA_WIDTH     = 16,
  parameter int           ADDR_WIDTH     = 13,
  parameter logic [1:0]   WRITE_STEP     = 2'h3,
  parameter bit           CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [1:0]              step,
  input  logic                    write_enable,
  input  logic [15:0]             write_address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_mask,
  input  logic                    read_enable,
  input  logic [15:0]             read_address,
  input  logic                    clear_start,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    read_valid,
  output logic                    busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = state_t'(CLEAR_ON_RESET ? CLEAR : IDLE);

  // Replace only the bytes selected by the mask; the rest keep the old word.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_BYTES-1:0]  mask
  );
    logic [DATA_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (mask[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  read_valid_q, read_valid_d;

  logic [ADDR_WIDTH-1:0] waddr_s, raddr_s, mem_addr_s;
  logic [DATA_WIDTH-1:0] wr_word_s, mem_wdata_s;
  logic                  wr_commit_s, rd_accept_s, mem_we_s, mem_wr_s;
  logic                  unused_addr_s;

  // Upper address bits alias onto the implemented depth.
  assign waddr_s       = write_address[ADDR_WIDTH-1:0];
  assign raddr_s       = read_address[ADDR_WIDTH-1:0];
  assign unused_addr_s = ^{write_address[15:ADDR_WIDTH], read_address[15:ADDR_WIDTH]};

  assign wr_commit_s = write_enable && (step == WRITE_STEP) && (state_q == IDLE);
  assign rd_accept_s = read_enable && (state_q == IDLE);
  assign wr_word_s   = merge_bytes(mem[waddr_s], data_in, byte_mask);

  // Memory is never touched while reset is held; only the sweep clears it.
  assign mem_wr_s = mem_we_s && reset_n;

  // Next-state, sweep counter, memory write port and read data selection.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    read_valid_d = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = waddr_s;
    mem_wdata_s  = wr_word_s;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
        mem_we_s = wr_commit_s;
        if (rd_accept_s) begin
          read_valid_d = 1'b1;
          if (wr_commit_s && (raddr_s == waddr_s)) begin
            data_out_d = wr_word_s;
          end else begin
            data_out_d = mem[raddr_s];
          end
        end else begin
          read_valid_d = 1'b0;
        end
      end
      CLEAR: begin
        mem_we_s    = 1'b1;
        mem_addr_s  = cnt_q;
        mem_wdata_s = '0;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RESET_STATE;
      cnt_q        <= '0;
      data_out_q   <= '0;
      read_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      read_valid_q <= read_valid_d;
    end
  end

  // Storage array write port; contents are not reset.
  always_ff @(posedge clock) begin
    if (mem_wr_s) begin
      mem[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign data_out   = data_out_q;
  assign read_valid = read_valid_q;
  assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_memory_array.sv
// Self-checking bench for memory_array (ADDR_WIDTH=4, 16-bit words).
// Expected read data is pushed to a queue when a read is issued and popped
// when the DUT raises read_valid.
module tb_memory_array;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  step;
  logic        write_enable;
  logic [15:0] write_address;
  logic [15:0] data_in;
  logic [1:0]  byte_mask;
  logic        read_enable;
  logic [15:0] read_address;
  logic        clear_start;
  logic [15:0] data_out;
  logic        read_valid;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] model_mem [16];
  logic [15:0] last_data = 16'h0000;
  int          sweep_len;

  always #5 clock = ~clock;

  memory_array #(
    .DATA_WIDTH    (16),
    .ADDR_WIDTH    (4),
    .WRITE_STEP    (2'h3),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .step         (step),
    .write_enable (write_enable),
    .write_address(write_address),
    .data_in      (data_in),
    .byte_mask    (byte_mask),
    .read_enable  (read_enable),
    .read_address (read_address),
    .clear_start  (clear_start),
    .data_out     (data_out),
    .read_valid   (read_valid),
    .busy         (busy)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    write_enable  = 1'b0;
    write_address = 16'h0000;
    data_in       = 16'h0000;
    byte_mask     = 2'b00;
    step          = 2'h0;
    read_enable   = 1'b0;
    read_address  = 16'h0000;
    clear_start   = 1'b0;
  endtask

  // Read-data scoreboard: every read_valid pulse consumes one expectation.
  always @(negedge clock) begin
    logic [15:0] e;
    if (reset_n && read_valid) begin
      if (exp_q.size() == 0) begin
        check_value("spurious_read_valid", 32'(read_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check_value("read_data", 32'(data_out), 32'(e));
        last_data = e;
      end
    end
  end

  // One cycle of stimulus: applied at a negedge, sampled by the next posedge.
  task automatic op(input logic we, input logic [15:0] wa, input logic [15:0] din,
                    input logic [1:0] msk, input logic [1:0] stp,
                    input logic re, input logic [15:0] ra, input logic exp_busy);
    logic        commit;
    logic [15:0] merged;
    logic [3:0]  wi, ri;
    wi     = wa[3:0];
    ri     = ra[3:0];
    commit = we && (stp == 2'h3) && !exp_busy;
    merged = model_mem[wi];
    if (msk[0]) merged[7:0]  = din[7:0];
    if (msk[1]) merged[15:8] = din[15:8];
    if (re && !exp_busy) begin
      exp_q.push_back((commit && (wi == ri)) ? merged : model_mem[ri]);
    end
    if (commit) model_mem[wi] = merged;
    write_enable  = we;
    write_address = wa;
    data_in       = din;
    byte_mask     = msk;
    step          = stp;
    read_enable   = re;
    read_address  = ra;
    @(negedge clock);
    drive_idle();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m, input logic [1:0] s);
    op(1'b1, a, d, m, s, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a);
    op(1'b0, 16'h0000, 16'h0000, 2'b00, 2'h0, 1'b1, a, 1'b0);
  endtask

  // Count busy cycles of a sweep; mid-sweep it tries a write, read and
  // clear_start that must all be dropped.
  task automatic count_sweep(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busy) break;
      n++;
      if (n == 12) begin
        write_enable  = 1'b1;
        write_address = 16'h0002;
        data_in       = 16'hFFFF;
        byte_mask     = 2'b11;
        step          = 2'h3;
        read_enable   = 1'b1;
        read_address  = 16'h0002;
        clear_start   = 1'b1;
      end else begin
        drive_idle();
      end
    end
    drive_idle();
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    drive_idle();
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;

    // Reset state.
    repeat (2) @(negedge clock);
    check_value("rst_data_out", 32'(data_out), 32'h0);
    check_value("rst_read_valid", 32'(read_valid), 32'h0);
    check_value("rst_busy", 32'(busy), 32'h1);

    // Power-on sweep lasts exactly DEPTH cycles, then every word reads zero.
    @(posedge clock);
    #1 reset_n = 1'b1;
    count_sweep(sweep_len);
    check_value("sweep_len", 32'(sweep_len), 32'd16);
    for (int a = 0; a < 16; a++) rd(16'(a));

    // Step gating: wrong step does not commit, matching step does.
    wr(16'h0005, 16'hBEEF, 2'b11, 2'h2);
    rd(16'h0005);
    wr(16'h0005, 16'hBEEF, 2'b11, 2'h3);
    rd(16'h0005);

    // Byte mask: only the low byte changes.
    wr(16'h0007, 16'h1234, 2'b11, 2'h3);
    wr(16'h0007, 16'hABCD, 2'b01, 2'h3);
    rd(16'h0007);
    wr(16'h0007, 16'h9900, 2'b10, 2'h3);
    rd(16'h0007);

    // Write-first bypass on the same address.
    op(1'b1, 16'h0009, 16'h5A5A, 2'b11, 2'h3, 1'b1, 16'h0009, 1'b0);
    // Simultaneous write/read to different addresses returns stored data.
    op(1'b1, 16'h000A, 16'h7777, 2'b11, 2'h3, 1'b1, 16'h0009, 1'b0);
    rd(16'h000A);

    // With no read, read_valid stays low and data_out holds.
    op(1'b0, 16'h0000, 16'h0000, 2'b00, 2'h0, 1'b0, 16'h0000, 1'b0);
    op(1'b0, 16'h0000, 16'h0000, 2'b00, 2'h0, 1'b0, 16'h0000, 1'b0);
    check_value("hold_read_valid", 32'(read_valid), 32'h0);
    check_value("hold_data_out", 32'(data_out), 32'(last_data));

    // Address aliasing onto the 16-word array.
    wr(16'h0013, 16'h1111, 2'b11, 2'h3);
    rd(16'h0003);
    wr(16'hFFF4, 16'h4444, 2'b11, 2'h3);
    rd(16'h0004);
    op(1'b0, 16'h0000, 16'h0000, 2'b00, 2'h0, 1'b0, 16'h0000, 1'b0);
    op(1'b0, 16'h0000, 16'h0000, 2'b00, 2'h0, 1'b0, 16'h0000, 1'b0);
    check_value("queue_drained_pre_sweep", 32'(exp_q.size()), 32'h0);

    // Runtime sweep interrupted by reset at sweep cycle 6.
    clear_start = 1'b1;
    @(negedge clock);
    clear_start = 1'b0;
    check_value("clear_busy", 32'(busy), 32'h1);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_value("mid_rst_busy", 32'(busy), 32'h1);
    check_value("mid_rst_read_valid", 32'(read_valid), 32'h0);
    check_value("mid_rst_data_out", 32'(data_out), 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    count_sweep(sweep_len);
    check_value("restart_sweep_len", 32'(sweep_len), 32'd16);
    rd(16'h0002);
    rd(16'h0003);
    rd(16'h0005);
    rd(16'h0007);
    rd(16'h0009);
    rd(16'h000A);
    op(1'b0, 16'h0000, 16'h0000, 2'b00, 2'h0, 1'b0, 16'h0000, 1'b0);
    op(1'b0, 16'h0000, 16'h0000, 2'b00, 2'h0, 1'b0, 16'h0000, 1'b0);
    check_value("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_array.md
MEMORY_ARRAY -- requirements
Module: memory_array

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 13: SHALL set depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter WRITE_STEP, default 2'h3: SHALL be the step value at which writes commit.
REQ-004 Parameter CLEAR_ON_RESET, default 1: when 1, SHALL zero-sweep memory after reset release.
REQ-005 clock  input  1: SHALL be the single clock; all state SHALL change on its rising edge.
REQ-006 reset_n  input  1: SHALL be the asynchronous, active-low reset.
REQ-007 step  input  2: SHALL be the CPU step phase.
REQ-008 write_enable  input  1: SHALL be the write request.
REQ-009 write_address  input  16: SHALL be the write word address.
REQ-010 data_in  input  DATA_WIDTH: SHALL be the write data.
REQ-011 byte_mask  input  DATA_WIDTH/8: SHALL give per-byte write enables; bit i covers bits 8i+7..8i.
REQ-012 read_enable  input  1: SHALL be the read request.
REQ-013 read_address  input  16: SHALL be the read word address.
REQ-014 clear_start  input  1: SHALL request a runtime zero-sweep.
REQ-015 data_out  output  DATA_WIDTH: SHALL be the registered read data.
REQ-016 read_valid  output  1: SHALL flag data_out updated this cycle.
REQ-017 busy  output  1: SHALL flag a sweep in progress.

Function
REQ-018 Addresses SHALL use only bits ADDR_WIDTH-1:0; upper bits SHALL be ignored (aliasing).
REQ-019 Write commit SHALL require write_enable=1, step=WRITE_STEP and busy=0; only bytes with byte_mask=1 SHALL change.
REQ-020 Read SHALL require read_enable=1 and busy=0; data_out SHALL update one cycle later and read_valid SHALL pulse high for exactly that cycle.
REQ-021 With no accepted read, data_out SHALL hold its value and read_valid SHALL be 0.
REQ-022 Read and committing write to the same address in one cycle SHALL return the merged new word (write-first bypass); to different addresses, SHALL return the old read-address contents.
REQ-023 The FSM SHALL have states IDLE and CLEAR; busy SHALL be 1 exactly in CLEAR.
REQ-024 IDLE -> CLEAR SHALL occur on clear_start=1; the sweep counter SHALL load 0.
REQ-025 In CLEAR, each cycle SHALL write all-zero to the counter address and increment the counter.
REQ-026 After writing address DEPTH-1, the FSM SHALL return to IDLE; a sweep SHALL last exactly DEPTH cycles.
REQ-027 In CLEAR, clear_start, write and read requests SHALL be ignored and dropped, not queued.
REQ-028 The sweep counter SHALL be ADDR_WIDTH bits wide and SHALL NOT wrap past DEPTH-1.

Reset
REQ-029 With reset_n=0: data_out=0, read_valid=0, sweep counter=0.
REQ-030 With reset_n=0: FSM=CLEAR and busy=1 if CLEAR_ON_RESET=1, else FSM=IDLE and busy=0.
REQ-031 Memory contents SHALL NOT be altered by reset itself, only by the sweep.
REQ-032 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release (CLEAR_ON_RESET=1), or abort it (CLEAR_ON_RESET=0).

Verification
REQ-033 Sweep: CLEAR_ON_RESET=1, ADDR_WIDTH=4, release reset -> busy=1 for 16 cycles, then 0; reading addresses 0..15 -> 0x0000 each, read_valid pulsing.
REQ-034 Step gating: write 0xBEEF to 5 with step=2, then step=3 -> read 5 returns 0x0000 after first attempt, 0xBEEF after second.
REQ-035 Byte mask: word 7=0x1234; write 0xABCD, byte_mask=2'b01, step=3 -> read 7 returns 0x12CD.
REQ-036 Bypass: write 0x5A5A to 9 and read 9 in same cycle (step=3) -> next cycle data_out=0x5A5A, read_valid=1.
REQ-037 Aliasing: ADDR_WIDTH=4, write 0x1111 to 0x0013 -> read 0x0003 returns 0x1111.
REQ-038 Mid-sweep: clear_start, reset_n low for 1 cycle at sweep cycle 6, release -> busy=1 for a full 16 further cycles; writes during busy leave memory 0.
